cla_word_sequencer: RTL and testbench

//  Multi-cycle controller for one shared NBIT-wide decomposed CLA slice
//  (gen_nonlinear_part plus its linear/sum part, fully combinational).

---
 rtl/cla_word_sequencer.sv | 144 ++++++++++++++
 tb/tb_cla_word_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: multi-cycle controller for one shared NBIT-wide CLA slice.
// Accepts a wide operand pair, feeds the slice one word per cycle (LSW first)
// while chaining the carry, and returns the registered wide sum and carry-out.
// Optional feature macro: SIGNED_OVF_EN adds a registered signed-overflow flag (ovf).
module cla_word_sequencer #(
    parameter int unsigned NBIT   = 4,
    parameter int unsigned NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NBIT*NWORDS-1:0]   op_a,
    input  logic [NBIT*NWORDS-1:0]   op_b,
    input  logic                     op_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NBIT*NWORDS-1:0]   sum,
    output logic                     cout,
    output logic                     busy,
    output logic [NBIT-1:0]          add_a,
    output logic [NBIT-1:0]          add_b,
    output logic                     add_cin,
    input  logic [NBIT-1:0]          add_sum,
    input  logic                     add_cout
`ifdef SIGNED_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int unsigned W    = NBIT * NWORDS;
    localparam int unsigned IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              carry_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              accept;
    logic              last_word;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign last_word = (idx_q == IDXW'(NWORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_word) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags decoded from state; slice inputs driven only in RUN
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_q[idx_q*NBIT +: NBIT];
                add_b   = b_q[idx_q*NBIT +: NBIT];
                add_cin = carry_q;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, per-word sum write-back and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= op_cin;
            sum_q   <= '0;
        end else if (state_q == S_RUN) begin
            sum_q[idx_q*NBIT +: NBIT] <= add_sum;
            carry_q                   <= add_cout;
            if (last_word) begin
                cout_q <= add_cout;
            end else begin
                idx_q <= idx_q + IDXW'(1);
            end
        end
    end

`ifdef SIGNED_OVF_EN
    logic ovf_q;

    // Signed overflow: operands share a sign that the top result bit does not
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if ((state_q == S_RUN) && last_word) begin
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_sum[NBIT-1] != a_q[W-1]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer (NBIT=4, NWORDS=4) with a
// behavioural a+b+c slice; results compared against plain wide arithmetic.
module tb_cla_word_sequencer;

    localparam int unsigned NBIT   = 4;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned W      = NBIT * NWORDS;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            op_cin;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    sum;
    logic            cout;
    logic            busy;
    logic [NBIT-1:0] add_a;
    logic [NBIT-1:0] add_b;
    logic            add_cin;
    logic [NBIT-1:0] add_sum;
    logic            add_cout;
`ifdef SIGNED_OVF_EN
    logic            ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Observations captured by do_op
    int              obs_lat;
    logic [W-1:0]    obs_sum;
    logic            obs_cout;
    logic            obs_ovf;
    logic [NBIT-1:0] obs_a   [NWORDS];
    logic [NBIT-1:0] obs_b   [NWORDS];
    logic            obs_cin [NWORDS];

    cla_word_sequencer #(.NBIT(NBIT), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Behavioural CLA slice
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width sum with carry-out
    function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    endfunction

    // Reference: carry entering word i of the chained addition
    function automatic logic ref_word_cin(logic [W-1:0] a, logic [W-1:0] b, logic c, int i);
        longint unsigned m, s;
        m = (64'd1 << (NBIT * i)) - 64'd1;
        s = (64'(a) & m) + (64'(b) & m) + 64'(c);
        return s[NBIT*i];
    endfunction

    function automatic logic ref_ovf(logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W:0] r;
        r = ref_add(a, b, c);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    // Offer one operand pair from IDLE and follow it to DONE; leaves it in DONE
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = c;
        tick;
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        obs_lat  = 0;
        while (!out_valid && obs_lat < 20) begin
            if (obs_lat < NWORDS) begin
                obs_a[obs_lat]   = add_a;
                obs_b[obs_lat]   = add_b;
                obs_cin[obs_lat] = add_cin;
            end
            tick;
            obs_lat++;
        end
        obs_sum  = sum;
        obs_cout = cout;
`ifdef SIGNED_OVF_EN
        obs_ovf  = ovf;
`else
        obs_ovf  = 1'b0;
`endif
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_flags: got ready/valid/busy=%b want 100", {in_ready, out_valid, busy});
        end
        n_vec++;
        if (sum !== '0 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_result: got sum=%h cout=%b want 0000/0", sum, cout);
        end
        n_vec++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            n_err++;
            $display("FAIL reset_slice: got a=%h b=%h cin=%b want 0/0/0", add_a, add_b, add_cin);
        end
`ifdef SIGNED_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_directed;
        logic [W-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [W-1:0] vb [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0000};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W:0]   want [4] = '{17'h05555, 17'h10000, 17'h10000, 17'h00001};
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], vc[k]);
            n_vec++;
            if (obs_lat !== NWORDS) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d cycles want %0d", k, obs_lat, NWORDS);
            end
            n_vec++;
            if ({obs_cout, obs_sum} !== want[k]) begin
                n_err++;
                $display("FAIL dir%0d_result: got cout=%b sum=%h want cout=%b sum=%h",
                         k, obs_cout, obs_sum, want[k][W], want[k][W-1:0]);
            end
            if (k == 1) begin
                for (int i = 0; i < NWORDS; i++) begin
                    n_vec++;
                    if (obs_cin[i] !== (i != 0)) begin
                        n_err++;
                        $display("FAIL dir1_carry_w%0d: got %b want %b", i, obs_cin[i], (i != 0));
                    end
                end
            end
            release_out;
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_release: got ready=%b valid=%b want 1/0", k, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_stall;
        logic [W:0] r;
        r = ref_add(16'hA5A5, 16'h5A5B, 1'b0);
        do_op(16'hA5A5, 16'h5A5B, 1'b0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== r) begin
                n_err++;
                $display("FAIL stall_c%0d: got valid=%b ready=%b cout=%b sum=%h want 1/0/%b/%h",
                         c, out_valid, in_ready, cout, sum, r[W], r[W-1:0]);
            end
            tick;
        end
        release_out;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || {cout, sum} !== r) begin
            n_err++;
            $display("FAIL stall_release: got ready=%b busy=%b cout=%b sum=%h want 1/0/%b/%h",
                     in_ready, busy, cout, sum, r[W], r[W-1:0]);
        end
    endtask

    task automatic test_abort;
        // Leave cout=1 behind so the abort must clear it
        do_op(16'hFFFF, 16'h0001, 1'b0);
        release_out;
        in_valid = 1'b1;
        op_a     = 16'h1234;
        op_b     = 16'h4321;
        op_cin   = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_flags: got ready/valid/busy=%b want 100", {in_ready, out_valid, busy});
        end
        n_vec++;
        if (sum !== '0 || cout !== 1'b0 || add_a !== '0 || add_b !== '0) begin
            n_err++;
            $display("FAIL abort_state: got sum=%h cout=%b a=%h b=%h want 0", sum, cout, add_a, add_b);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   r;
        for (int t = 0; t < 30; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            if (t % 5 == 0) b = ~a;
            r = ref_add(a, b, c);
            do_op(a, b, c);
            n_vec++;
            if (obs_lat !== NWORDS || {obs_cout, obs_sum} !== r) begin
                n_err++;
                $display("FAIL rand%0d: %h+%h+%b got lat=%0d cout=%b sum=%h want lat=%0d cout=%b sum=%h",
                         t, a, b, c, obs_lat, obs_cout, obs_sum, NWORDS, r[W], r[W-1:0]);
            end
            for (int i = 0; i < NWORDS; i++) begin
                n_vec++;
                if (obs_a[i] !== a[i*NBIT +: NBIT] || obs_b[i] !== b[i*NBIT +: NBIT]
                    || obs_cin[i] !== ref_word_cin(a, b, c, i)) begin
                    n_err++;
                    $display("FAIL rand%0d_word%0d: got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                             t, i, obs_a[i], obs_b[i], obs_cin[i],
                             a[i*NBIT +: NBIT], b[i*NBIT +: NBIT], ref_word_cin(a, b, c, i));
                end
            end
`ifdef SIGNED_OVF_EN
            n_vec++;
            if (obs_ovf !== ref_ovf(a, b, c)) begin
                n_err++;
                $display("FAIL rand%0d_ovf: got %b want %b", t, obs_ovf, ref_ovf(a, b, c));
            end
`endif
            release_out;
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp_q [$];
        logic [W:0] e;
        int last_acc;
        int n_acc;
        bit acc;
        last_acc  = -1;
        n_acc     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = W'($urandom);
        op_b      = W'($urandom);
        op_cin    = 1'($urandom);
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = 1'b0;
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_vec++;
                if ({cout, sum} !== e) begin
                    n_err++;
                    $display("FAIL b2b_result c%0d: got cout=%b sum=%h want cout=%b sum=%h",
                             cyc, cout, sum, e[W], e[W-1:0]);
                end
            end
            if (in_ready) begin
                if (last_acc >= 0) begin
                    n_vec++;
                    if (cyc - last_acc !== NWORDS + 2) begin
                        n_err++;
                        $display("FAIL b2b_interval: got %0d want %0d", cyc - last_acc, NWORDS + 2);
                    end
                end
                exp_q.push_back(ref_add(op_a, op_b, op_cin));
                last_acc = cyc;
                n_acc++;
                acc = 1'b1;
            end
            tick;
            if (acc) begin
                op_a   = W'($urandom);
                op_b   = W'($urandom);
                op_cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({cout, sum} !== e) begin
                    n_err++;
                    $display("FAIL b2b_drain: got cout=%b sum=%h want cout=%b sum=%h",
                             cout, sum, e[W], e[W-1:0]);
                end
            end
            tick;
        end
        out_ready = 1'b0;
        n_vec++;
        if (exp_q.size() != 0 || n_acc < 5 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drain_state: got pending=%0d accepts=%0d ready=%b want 0/>=5/1",
                     exp_q.size(), n_acc, in_ready);
        end
    endtask

`ifdef SIGNED_OVF_EN
    task automatic test_ovf;
        logic [W-1:0] va [3] = '{16'h7FFF, 16'h8000, 16'h1234};
        logic [W-1:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h4321};
        logic [1:0]   want [3] = '{2'b10, 2'b11, 2'b00};
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], 1'b0);
            n_vec++;
            if ({obs_ovf, obs_cout} !== want[k]) begin
                n_err++;
                $display("FAIL ovf%0d: got ovf=%b cout=%b want ovf=%b cout=%b",
                         k, obs_ovf, obs_cout, want[k][1], want[k][0]);
            end
            release_out;
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        test_reset;
        test_directed;
        test_stall;
        test_abort;
        test_random;
        test_back_to_back;
`ifdef SIGNED_OVF_EN
        test_ovf;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
